snes_pad_responder: RTL
=======================

Name: snes_pad_responder

Overview:
- Emulates an SNES game pad: the device end of the serial pad protocol whose host end is SNES_Control.
- Takes the host's latch and shift-clock lines, captures a 12-bit button word, and returns it serially on the data line.
- Used for loopback testing of SNES_Control on-board, without a physical pad, and as the pad model in benches.
- Runs on the system clk; host lines are asynchronous and synchronized internally.

Parameters:
- NUM_BUTTONS, 12, number of real buttons in the frame.
- FRAME_BITS, 16, total bits per frame; bits NUM_BUTTONS..FRAME_BITS-1 are padding.
- SYNC_STAGES, 2, flip-flop stages on each host input (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- data_latch  input  1  host latch, active high, asynchronous to clk.
- snes_clk  input  1  host shift clock, idles high, asynchronous to clk.
- buttons  input  NUM_BUTTONS  button state, 1 = pressed. Bit order: [0]=B, [1]=Y, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right, [8]=A, [9]=X, [10]=L, [11]=R.
- serial_data  output  1  pad data line, active low (0 = pressed).
- frame_strobe  output  1  one-cycle pulse when a frame is captured (latch falling edge).
- busy  output  1  high while frame bits remain to be shifted.

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE, serial_data=1, frame_strobe=0, busy=0, bit_cnt=0, shift register all 1s.
  - Synchronizer flops are cleared to latch=0, clk=1, so no spurious edge is seen after reset.
- Synchronization:
  - Each host input passes through SYNC_STAGES flops, then a one-flop edge detector.
  - An input change is acted on SYNC_STAGES+1 clk cycles after it occurs.
- Frame word:
  - shreg[FRAME_BITS-1:0] = {padding 1s, ~buttons}.
  - Data is inverted because the line is active low; padding bits are always 1.
- States:
  - IDLE:
    - serial_data=1; snes_clk edges are ignored.
    - Synced latch high -> LOAD.
  - LOAD (latch high):
    - shreg is reloaded from buttons every cycle (transparent capture).
    - serial_data = shreg[0], so it follows live ~buttons[0].
    - Latch falling edge -> shreg frozen, frame_strobe=1 for that cycle, bit_cnt=0, busy=1, go to SHIFT.
  - SHIFT:
    - serial_data = shreg[0] (registered output).
    - On each synced snes_clk rising edge: shreg shifts right, filling 0 at the MSB; bit_cnt increments.
    - When bit_cnt reaches FRAME_BITS-1 and a rising edge occurs, go to DONE.
    - Falling edges of snes_clk cause no action; the host samples on them.
  - DONE:
    - serial_data=0 and busy=0, matching the line held low after the 16th clock.
    - Further snes_clk edges are ignored.
    - Latch high -> LOAD.
- Boundary conditions:
  - Latch rises mid-SHIFT: abort the frame, busy=0, go to LOAD; no partial bits survive.
  - Latch edge and snes_clk edge in the same cycle: the latch edge wins and the clock edge is dropped.
  - More than FRAME_BITS clock pulses: the extras read 0 and the state stays DONE.
  - Fewer than FRAME_BITS pulses before the next latch: the remaining bits are discarded.
  - buttons changes during SHIFT: no effect on the current frame.
  - Reset mid-frame: immediate return to the reset values above.
- Width rules:
  - bit_cnt width = $clog2(FRAME_BITS).
  - The compare is an exact equality, with no wraparound.

Decomposition:
- Shared package snes_pkg:
  - Button index localparams (BTN_B..BTN_R).
  - SNES_FRAME_BITS=16, SNES_NUM_BUTTONS=12.
  - State encoding enum {IDLE, LOAD, SHIFT, DONE}.
  - SNES_Control is to share the same constants.
- Sub-module sync_edge:
  - Contents: SYNC_STAGES synchronizer plus rise/fall pulse outputs, with a parameterized reset value.
  - Instantiated for data_latch (reset 0) and snes_clk (reset 1).

Test Plan:
1. Reset held low for 3 cycles, with snes_clk=1, data_latch=0 -> serial_data=1, busy=0, frame_strobe=0; no strobe on reset release.
2. buttons=12'h001 (B pressed); 12 us latch pulse, then 16 snes_clk pulses (6 us period) -> bits sampled on falling edges = 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1. frame_strobe pulses exactly once; busy falls after the 16th rising edge; serial_data=0 afterwards.
3. buttons=12'hA5C; full frame -> sampled bits equal ~12'hA5C LSB-first, then 1111. Looping SNES_Control against the block yields button_data=12'hA5C.
4. Latch re-asserted after 5 clocks, with buttons changed from 12'hFFF to 12'h000 -> the new frame shifts all 1s for bits 0-11; the old frame's remaining bits never appear.
5. Twenty clock pulses after one latch -> pulses 17-20 read 0 and the state stays DONE. A buttons change during SHIFT does not alter the current frame bits.
6. Reset asserted after 8 shifted bits -> next cycle serial_data=1, busy=0. A following latch and frame shifts correctly from bit 0.

Source files
------------

// File: rtl/snes_pkg.sv
// snes_pkg: constants and state encoding shared by the SNES pad host and device ends
package snes_pkg;

    localparam int SNES_NUM_BUTTONS = 12;
    localparam int SNES_FRAME_BITS  = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pad_state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous line with rise/fall pulses
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // shift the raw line through the synchronizer and keep one extra flop for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/snes_pad_responder.sv
// snes_pad_responder: device end of the SNES pad serial protocol, shifts out a captured button word
module snes_pad_responder
    import snes_pkg::*;
#(
    parameter int NUM_BUTTONS = SNES_NUM_BUTTONS,
    parameter int FRAME_BITS  = SNES_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_latch,
    input  logic                   snes_clk,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic                   serial_data,
    output logic                   frame_strobe,
    output logic                   busy
);

    localparam int CW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

    pad_state_e            state_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [CW-1:0]         bit_cnt_q;
    logic                  serial_q;
    logic                  strobe_q;
    logic                  busy_q;

    logic                  latch_lvl, latch_rise, latch_fall;
    logic                  sclk_lvl, sclk_rise, sclk_fall;
    logic                  unused_sclk;
    logic [FRAME_BITS-1:0] load_word;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_latch_sync (
        .clk  (clk),
        .reset(reset),
        .d    (data_latch),
        .q    (latch_lvl),
        .rise (latch_rise),
        .fall (latch_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk  (clk),
        .reset(reset),
        .d    (snes_clk),
        .q    (sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // the host samples on falling edges, so only rising edges move the frame
    assign unused_sclk = sclk_lvl ^ sclk_fall;

    // the line is active low and padding bits read as released
    assign load_word = {{(FRAME_BITS - NUM_BUTTONS){1'b1}}, ~buttons};

    // pad protocol FSM; latch edges take priority over a simultaneous shift clock edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '1;
            bit_cnt_q <= '0;
            serial_q  <= 1'b1;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (latch_lvl) begin
                        state_q  <= LOAD;
                        shreg_q  <= load_word;
                        serial_q <= load_word[0];
                    end
                end
                LOAD: begin
                    if (latch_fall) begin
                        state_q   <= SHIFT;
                        strobe_q  <= 1'b1;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end else begin
                        shreg_q  <= load_word;
                        serial_q <= load_word[0];
                    end
                end
                SHIFT: begin
                    if (latch_rise) begin
                        state_q  <= LOAD;
                        busy_q   <= 1'b0;
                        shreg_q  <= load_word;
                        serial_q <= load_word[0];
                    end else if (sclk_rise) begin
                        shreg_q   <= {1'b0, shreg_q[FRAME_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            serial_q <= 1'b0;
                        end else begin
                            serial_q <= shreg_q[1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serial_data  = serial_q;
    assign frame_strobe = strobe_q;
    assign busy         = busy_q;

endmodule
